// File: rtl/ivector_respond_arbiter_pkg.sv
// Shared constants for the ivector response arbiter: default geometry and lane-index width.
package ivector_respond_arbiter_pkg;

   localparam int NUM_LANES_DEF = 10;
   localparam int DATA_W_DEF    = 32;
   localparam int METH_W_DEF    = 32;

   // A single lane still needs one index bit so that vectors never collapse to zero width.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int LANE_IDX_W = idx_w(NUM_LANES_DEF);

endpackage

// File: rtl/ivector_respond_arbiter_rr_pick.sv
// Rotating-priority pick: the first set request found searching upward from ptr, with wrap.
module rr_pick
   import ivector_respond_arbiter_pkg::*;
#(
   parameter int N     = NUM_LANES_DEF,
   parameter int IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         // ptr is always below N, so ptr + k wraps with a single subtraction.
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
         end
         idx = sum[IDX_W-1:0];
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/ivector_respond_arbiter.sv
// Round-robin arbiter draining NUM_LANES response FIFOs into a single one-entry indication slot.
module ivector_respond_arbiter
   import ivector_respond_arbiter_pkg::*;
#(
   parameter int NUM_LANES = NUM_LANES_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int METH_W    = METH_W_DEF
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic [NUM_LANES-1:0]        lane_rdy,
   input  logic [NUM_LANES*DATA_W-1:0] lane_data,
   output logic [NUM_LANES-1:0]        lane_deq__ENA,
   output logic                        heard__ENA,
   output logic [METH_W-1:0]           heard_meth,
   output logic [DATA_W-1:0]           heard_v,
   input  logic                        heard__RDY,
   output logic [31:0]                 grant_count
);

   localparam int IDX_W = idx_w(NUM_LANES);

   logic                 out_valid_q, out_valid_d;
   logic [METH_W-1:0]    out_meth_q, out_meth_d;
   logic [DATA_W-1:0]    out_v_q, out_v_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [31:0]          grant_count_q, grant_count_d;

   logic [NUM_LANES-1:0] pick_gnt;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 slot_free;
   logic                 sel;
   logic [DATA_W-1:0]    lane_arr [NUM_LANES];

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_arr[i] = lane_data[i*DATA_W +: DATA_W];
      end
   end

   rr_pick #(
      .N     (NUM_LANES),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req     (lane_rdy),
      .ptr     (rr_ptr_q),
      .gnt     (pick_gnt),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   assign heard__ENA    = out_valid_q & heard__RDY;
   assign heard_meth    = out_meth_q;
   assign heard_v       = out_v_q;
   assign grant_count   = grant_count_q;
   assign slot_free     = ~out_valid_q | heard__ENA;
   // Gated by nRST so no FIFO is popped while the slot is being cleared by reset.
   assign sel           = slot_free & pick_any & nRST;
   assign lane_deq__ENA = sel ? pick_gnt : '0;

   always_comb begin
      out_valid_d   = out_valid_q;
      out_meth_d    = out_meth_q;
      out_v_d       = out_v_q;
      rr_ptr_d      = rr_ptr_q;
      grant_count_d = grant_count_q + {31'b0, heard__ENA};
      if (sel) begin
         out_valid_d = 1'b1;
         out_meth_d  = METH_W'(pick_idx);
         out_v_d     = lane_arr[pick_idx];
         rr_ptr_d    = (pick_idx == IDX_W'(NUM_LANES-1)) ? '0 : pick_idx + IDX_W'(1);
      end else if (heard__ENA) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_valid_q   <= 1'b0;
         out_meth_q    <= '0;
         out_v_q       <= '0;
         rr_ptr_q      <= '0;
         grant_count_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_meth_q    <= out_meth_d;
         out_v_q       <= out_v_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_count_q <= grant_count_d;
      end
   end

endmodule

// File: doc/ivector_respond_arbiter.md
IVECTOR_RESPOND_ARBITER -- requirements
Module: ivector_respond_arbiter

Interface
REQ-001 The block SHALL have these parameters: NUM_LANES, default 10, number of response FIFO lanes; DATA_W, default 32, response payload width; METH_W, default 32, method-index width.
REQ-002 CLK  in  1  sole clock; all state on rising edge.
REQ-003 nRST  in  1  reset, asynchronous and active-low.
REQ-004 lane_rdy  in  NUM_LANES  bit i = lane i first__RDY AND deq__RDY.
REQ-005 lane_data  in  NUM_LANES*DATA_W  lane i first payload, bits [i*DATA_W +: DATA_W].
REQ-006 lane_deq__ENA  out  NUM_LANES  one-hot dequeue strobe to lane i FIFO.
REQ-007 heard__ENA  out  1  indication fires this cycle.
REQ-008 heard_meth  out  METH_W  lane index of delivered payload, zero-extended.
REQ-009 heard_v  out  DATA_W  delivered payload.
REQ-010 heard__RDY  in  1  indication sink can accept.
REQ-011 grant_count  out  32  total indications delivered since reset.

Function
REQ-012 The block SHALL hold a one-entry output register (out_valid, out_meth, out_v) and a round-robin pointer rr_ptr in 0..NUM_LANES-1.
REQ-013 heard__ENA SHALL equal out_valid AND heard__RDY; heard_meth/heard_v SHALL be driven from out_meth/out_v.
REQ-014 slot_free SHALL equal NOT out_valid OR heard__ENA.
REQ-015 When slot_free and any lane_rdy is set, the block SHALL select the first set lane searching from rr_ptr upward with wrap at NUM_LANES-1 to 0.
REQ-016 In a selection cycle, lane_deq__ENA SHALL pulse for exactly that lane, and out_v/out_meth SHALL load that lane's data/index at the clock edge, with out_valid set.
REQ-017 After a grant to lane g, rr_ptr SHALL become g+1, wrapping to 0 when g = NUM_LANES-1.
REQ-018 When slot_free and no lane_rdy is set, out_valid SHALL clear if heard__ENA, lane_deq__ENA SHALL be 0, and rr_ptr SHALL hold.
REQ-019 Latency: a lane becoming ready with the slot empty SHALL produce heard__ENA on the next cycle, provided heard__RDY is high.
REQ-020 Back-to-back: with heard__RDY held high and lanes ready, the block SHALL deliver one indication per cycle, with no bubble.
REQ-021 With heard__RDY low and out_valid set, output registers, rr_ptr and lane_deq__ENA (0) SHALL all hold.
REQ-022 lane_deq__ENA SHALL never be asserted for a lane whose lane_rdy is 0, and SHALL be at most one-hot.
REQ-023 grant_count SHALL increment by 1 on each heard__ENA cycle, wrapping modulo 2^32.
REQ-024 A lane de-asserting lane_rdy in a cycle SHALL lose that cycle's arbitration with no retained request state.

Reset
REQ-025 While nRST is low: out_valid=0, out_meth=0, out_v=0, rr_ptr=0, grant_count=0; heard__ENA=0 and lane_deq__ENA=0 combinationally.
REQ-026 Reset asserted mid-transfer SHALL discard any held payload; the dequeued entry is lost, which is accepted behaviour.
REQ-027 The first selection after reset release SHALL search from lane 0.

Structure
REQ-028 NUM_LANES, DATA_W, METH_W defaults and a lane-index width constant (clog2 NUM_LANES) SHALL live in the shared ivector package.
REQ-029 The rotating priority pick SHALL be one sub-module, rr_pick (inputs: request vector, pointer; outputs: one-hot grant, grant index, any).

Verification
REQ-030 Reset: hold lane_rdy=all ones during reset -> heard__ENA=0, lane_deq__ENA=0, grant_count=0; after release, cycle 1 deq lane 0, cycle 2 heard_meth=0.
REQ-031 Fairness: all 10 lanes ready, heard__RDY=1 for 20 cycles -> heard_meth sequence 0..9,0..9; grant_count=20.
REQ-032 Sparse: only lanes 3 and 7 ready, rr_ptr=5 -> lane 7 granted first, then 3, then 7.
REQ-033 Backpressure: out_valid holding lane 2 data 0xDEADBEEF, heard__RDY=0 for 5 cycles -> no deq; heard_v stable; on release one heard__ENA with 0xDEADBEEF and new grant same cycle.
REQ-034 Wrap: only lane 9 ready, then lanes 0 and 9 ready -> after lane 9 grant, rr_ptr=0 and lane 0 granted next.
REQ-035 Mid-operation reset: nRST pulsed low while out_valid=1 -> out_valid=0 asynchronously; no heard__ENA for the discarded entry.
